ps2_scan_decoder: RTL and testbench

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

---
 rtl/ps2_scan_decoder.sv | 134 +++++++++++++
 tb/tb_ps2_scan_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext,brk,code} key events and queues them in a FIFO.
// Latency: scan_ready rising at clk edge k gives read in cycle k+3 and key_valid from cycle k+4 (empty FIFO).
// Backpressure: consumer stalls with key_ready=0; events arriving while full are dropped and flag overflow.
//
// Ports:
//   clk, reset       - system clock, asynchronous active-low reset
//   scan_code/ready  - byte and level-valid from the PS/2 shift register (scan_ready asynchronous)
//   read             - one-cycle acknowledge back to the shift register
//   key_valid/ready  - head-of-FIFO handshake; key_code/key_ext/key_break describe the head event
//   fifo_count       - number of queued events; overflow - sticky dropped-event flag
module ps2_scan_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    scan_code,
   input  logic                          scan_ready,
   output logic                          read,
   output logic                          key_valid,
   input  logic                          key_ready,
   output logic [7:0]                    key_code,
   output logic                          key_ext,
   output logic                          key_break,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   logic [2:0]    sync_q;       // [0],[1] synchronizer, [2] previous synchronized value
   logic [1:0]    fill_q;
   logic          rise;
   logic [7:0]    byte_q;
   logic          read_q;
   state_t        state_q, state_d;
   logic          ext_f, brk_f, junk;
   logic          push_req;
   logic [9:0]    push_word;
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          full, pop, push;

   // After reset the chain holds zeros; a scan_ready already high would look like a
   // 0->1 transition while the chain refills. Edges are only honoured once all three
   // flops carry real samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= 3'b000;
         fill_q <= 2'd0;
      end else begin
         sync_q <= {sync_q[1:0], scan_ready};
         if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      end
   end

   assign rise = sync_q[1] & ~sync_q[2] & (fill_q == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_q <= 8'h00;
         read_q <= 1'b0;
      end else begin
         read_q <= rise;
         if (rise) byte_q <= scan_code;
      end
   end

   assign read = read_q;

   // Prefix state is just two flags: E0 sets ext, F0 sets brk, each keeping the other.
   assign ext_f = (state_q == EXT) || (state_q == EXT_BRK);
   assign brk_f = (state_q == BRK) || (state_q == EXT_BRK);
   assign junk  = (byte_q == 8'h00) || (byte_q == 8'hFF) || (byte_q == 8'hAA) || (byte_q == 8'hE1);

   always_comb begin
      state_d   = state_q;
      push_req  = 1'b0;
      push_word = 10'h000;
      if (read_q) begin
         if (byte_q == 8'hE0) begin
            state_d = brk_f ? EXT_BRK : EXT;
         end else if (byte_q == 8'hF0) begin
            state_d = ext_f ? EXT_BRK : BRK;
         end else if (junk) begin
            state_d = IDLE;
         end else begin
            push_req  = 1'b1;
            push_word = {ext_f, brk_f, byte_q};
            state_d   = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Event FIFO; a simultaneous pop frees the slot so a push at full still lands.
   assign key_valid = (count_q != '0);
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign pop       = key_valid & key_ready;
   assign push      = push_req & (~full | pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (push_req && !push) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_word;
   end

   assign {key_ext, key_break, key_code} = mem_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: expected key events are queued when bytes are sent
// and compared against the FIFO head when the consumer pops them.
module tb_ps2_scan_decoder;
   logic       clk;
   logic       reset;
   logic [7:0] scan_code;
   logic       scan_ready;
   logic       read;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic [2:0] fifo_count;
   logic       overflow;

   int errors = 0;
   int checks = 0;
   logic [9:0] sb[$];
   logic [9:0] exp_ev;
   bit         seen;

   ps2_scan_decoder #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .scan_code  (scan_code),
      .scan_ready (scan_ready),
      .read       (read),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_break  (key_break),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] next_exp();
      if (sb.size() > 0) return sb.pop_front();
      return 10'bx;
   endfunction

   // Presents one byte, waits for the acknowledge, optionally pops the head in the
   // same cycle the byte is classified, then releases scan_ready.
   task automatic send_byte(input logic [7:0] b, input bit pop_at_read);
      bit got;
      logic [9:0] e;
      got = 0;
      scan_code  = b;
      scan_ready = 1'b1;
      for (int n = 0; n < 12 && !got; n++) begin
         tick();
         if (read) got = 1;
      end
      chk("read_seen", got, 1);
      if (pop_at_read) begin
         e = next_exp();
         chk("head_at_full", {key_ext, key_break, key_code}, e);
         key_ready = 1'b1;
      end
      tick();
      key_ready = 1'b0;
      chk("read_one_pulse", read, 0);
      scan_ready = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pop_check(input string tag);
      bit got;
      logic [9:0] e;
      got = 0;
      for (int n = 0; n < 12 && !got; n++) begin
         if (key_valid) got = 1;
         else tick();
      end
      chk({tag, "_valid"}, got, 1);
      e = next_exp();
      chk({tag, "_event"}, {key_ext, key_break, key_code}, e);
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      scan_ready = 1'b0;
      scan_code  = 8'h00;
      key_ready  = 1'b0;
      repeat (3) tick();
      chk("rst_read", read, 0);
      chk("rst_valid", key_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);
      reset = 1'b1;
      repeat (4) tick();

      // Exact latency of a single make code with the consumer always ready
      key_ready  = 1'b1;
      scan_code  = 8'h1C;
      scan_ready = 1'b1;
      sb.push_back({2'b00, 8'h1C});
      tick(); chk("t1_read_k", read, 0);
      tick(); chk("t1_read_k1", read, 0);
      tick(); chk("t1_read_k2", read, 1);
      chk("t1_valid_early", key_valid, 0);
      tick(); chk("t1_read_k3", read, 0);
      chk("t1_valid", key_valid, 1);
      exp_ev = next_exp();
      chk("t1_event", {key_ext, key_break, key_code}, exp_ev);
      chk("t1_count1", fifo_count, 1);
      tick(); chk("t1_count0", fifo_count, 0);
      chk("t1_valid_off", key_valid, 0);
      scan_ready = 1'b0;
      key_ready  = 1'b0;
      repeat (4) tick();

      // Extended break: E0 F0 74
      send_byte(8'hE0, 0);
      send_byte(8'hF0, 0);
      sb.push_back({2'b11, 8'h74});
      send_byte(8'h74, 0);
      chk("t2_count", fifo_count, 1);
      pop_check("t2");
      chk("t2_count0", fifo_count, 0);

      // Repeated F0, then error/BAT/E1 bytes that must leave the FSM idle
      send_byte(8'hF0, 0);
      send_byte(8'hF0, 0);
      sb.push_back({2'b01, 8'h1C});
      send_byte(8'h1C, 0);
      chk("t3_count_brk", fifo_count, 1);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hE1, 0);
      chk("t3_count_junk", fifo_count, 1);
      sb.push_back({2'b00, 8'h2D});
      send_byte(8'h2D, 0);
      chk("t3_count2", fifo_count, 2);
      pop_check("t3a");
      pop_check("t3b");

      // Repeated E0, and a junk byte abandoning a pending break prefix
      send_byte(8'hE0, 0);
      send_byte(8'hE0, 0);
      sb.push_back({2'b10, 8'h75});
      send_byte(8'h75, 0);
      send_byte(8'hF0, 0);
      send_byte(8'hFF, 0);
      sb.push_back({2'b00, 8'h1C});
      send_byte(8'h1C, 0);
      pop_check("t3c");
      pop_check("t3d");

      // Overflow with the consumer stalled
      sb.push_back({2'b00, 8'h15}); send_byte(8'h15, 0);
      sb.push_back({2'b00, 8'h1D}); send_byte(8'h1D, 0);
      sb.push_back({2'b00, 8'h24}); send_byte(8'h24, 0);
      sb.push_back({2'b00, 8'h2D}); send_byte(8'h2D, 0);
      chk("t4_count_full", fifo_count, 4);
      chk("t4_ovf_clear", overflow, 0);
      send_byte(8'h2C, 0);
      send_byte(8'h35, 0);
      chk("t4_count_kept", fifo_count, 4);
      chk("t4_ovf_set", overflow, 1);

      // Push and pop together while full
      sb.push_back({2'b00, 8'h3C});
      send_byte(8'h3C, 1);
      chk("t5_count", fifo_count, 4);
      chk("t5_ovf", overflow, 1);
      pop_check("t5a");
      pop_check("t5b");
      pop_check("t5c");
      pop_check("t5d");
      chk("t5_count0", fifo_count, 0);

      // Pop on an empty FIFO is ignored
      key_ready = 1'b1;
      repeat (2) tick();
      key_ready = 1'b0;
      chk("empty_pop_count", fifo_count, 0);
      chk("empty_pop_valid", key_valid, 0);

      // Reset after a partial E0 F0 prefix
      send_byte(8'hE0, 0);
      send_byte(8'hF0, 0);
      reset = 1'b0;
      #1;
      chk("t6_rst_read", read, 0);
      chk("t6_rst_valid", key_valid, 0);
      chk("t6_rst_count", fifo_count, 0);
      chk("t6_rst_ovf", overflow, 0);
      sb.delete();
      repeat (2) tick();
      reset = 1'b1;
      repeat (4) tick();
      sb.push_back({2'b00, 8'h1C});
      send_byte(8'h1C, 0);
      pop_check("t6");
      chk("t6_count0", fifo_count, 0);

      // scan_ready already high when reset releases must not produce a byte
      reset      = 1'b0;
      scan_code  = 8'h5A;
      scan_ready = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      seen  = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         if (read) seen = 1;
      end
      chk("t7_no_edge", seen, 0);
      chk("t7_count", fifo_count, 0);
      scan_ready = 1'b0;
      repeat (4) tick();
      sb.push_back({2'b00, 8'h1C});
      send_byte(8'h1C, 0);
      pop_check("t7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
